// File: rtl/snn_pkg.sv
// Shared types and default sizing for the spiking classifier output stage.
package snn_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      SCAN  = 2'd2,
      HOLD  = 2'd3
   } state_e;

   localparam int CLASS_COUNT_DEF = 10;
   localparam int SCORE_WIDTH_DEF = 8;

endpackage

// File: rtl/spike_score_accum.sv
// Single-class signed saturating up/down spike score counter.
module spike_score_accum #(
   parameter int COUNT_WIDTH = 8
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          clr,
   input  logic                          en,
   input  logic                          pos,
   input  logic                          neg,
   output logic signed [COUNT_WIDTH-1:0] score
);

   localparam logic signed [COUNT_WIDTH-1:0] SCORE_MAX = {1'b0, {(COUNT_WIDTH-1){1'b1}}};
   localparam logic signed [COUNT_WIDTH-1:0] SCORE_MIN = {1'b1, {(COUNT_WIDTH-1){1'b0}}};

   logic signed [COUNT_WIDTH-1:0] score_q, score_d;

   // Next score: clear wins, otherwise net +1/-1 clamped at the signed limits.
   always_comb begin
      score_d = score_q;
      if (clr) begin
         score_d = '0;
      end else if (en && (pos != neg)) begin
         if (pos && (score_q != SCORE_MAX)) begin
            score_d = score_q + COUNT_WIDTH'(1);
         end else if (neg && (score_q != SCORE_MIN)) begin
            score_d = score_q - COUNT_WIDTH'(1);
         end
      end
   end

   // Score register.
   always_ff @(posedge clk) begin
      if (reset) begin
         score_q <= '0;
      end else begin
         score_q <= score_d;
      end
   end

   assign score = score_q;

endmodule

// File: rtl/spike_vote_classifier.sv
// Accumulates per-class net spike scores over a window, scans for the winner
// and presents it on a valid/ready handshake.
module spike_vote_classifier
   import snn_pkg::*;
#(
   parameter int CLASS_COUNT  = CLASS_COUNT_DEF,
   parameter int WINDOW_STEPS = 64,
   parameter int COUNT_WIDTH  = SCORE_WIDTH_DEF,
   parameter int IDX_WIDTH    = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic                   step_valid,
   input  logic [CLASS_COUNT-1:0] pos_spike_in,
   input  logic [CLASS_COUNT-1:0] neg_spike_in,
   output logic                   busy,
   output logic                   result_valid,
   input  logic                   result_ready,
   output logic [IDX_WIDTH-1:0]   class_idx,
   output logic [COUNT_WIDTH-1:0] class_score,
   output logic                   tie
);

   localparam int STEP_W = $clog2(WINDOW_STEPS + 1);

   state_e                        state_q, state_d;
   logic [STEP_W-1:0]             step_cnt_q, step_cnt_d;
   logic [IDX_WIDTH-1:0]          scan_idx_q, scan_idx_d;
   logic signed [COUNT_WIDTH-1:0] best_q, best_d;
   logic [IDX_WIDTH-1:0]          best_idx_q, best_idx_d;
   logic                          best_tie_q, best_tie_d;
   logic [IDX_WIDTH-1:0]          class_idx_q, class_idx_d;
   logic signed [COUNT_WIDTH-1:0] class_score_q, class_score_d;
   logic                          tie_q, tie_d;
   logic                          busy_q, busy_d;
   logic                          result_valid_q, result_valid_d;

   logic signed [COUNT_WIDTH-1:0] score [CLASS_COUNT];
   logic signed [COUNT_WIDTH-1:0] cand;
   logic                          clr_scores, step_en, last_step, last_idx, handshake;

   assign clr_scores = (state_q == IDLE) && start;
   assign step_en    = (state_q == ACCUM) && step_valid;
   assign last_step  = (step_cnt_q == STEP_W'(WINDOW_STEPS - 1));
   assign last_idx   = (scan_idx_q == IDX_WIDTH'(CLASS_COUNT - 1));
   assign handshake  = (state_q == HOLD) && result_valid_q && result_ready;
   assign cand       = score[scan_idx_q];

   for (genvar g = 0; g < CLASS_COUNT; g++) begin : g_class
      spike_score_accum #(
         .COUNT_WIDTH(COUNT_WIDTH)
      ) u_acc (
         .clk  (clk),
         .reset(reset),
         .clr  (clr_scores),
         .en   (step_en),
         .pos  (pos_spike_in[g]),
         .neg  (neg_spike_in[g]),
         .score(score[g])
      );
   end

   // State and datapath registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= IDLE;
         step_cnt_q     <= '0;
         scan_idx_q     <= '0;
         best_q         <= '0;
         best_idx_q     <= '0;
         best_tie_q     <= 1'b0;
         class_idx_q    <= '0;
         class_score_q  <= '0;
         tie_q          <= 1'b0;
         busy_q         <= 1'b0;
         result_valid_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         step_cnt_q     <= step_cnt_d;
         scan_idx_q     <= scan_idx_d;
         best_q         <= best_d;
         best_idx_q     <= best_idx_d;
         best_tie_q     <= best_tie_d;
         class_idx_q    <= class_idx_d;
         class_score_q  <= class_score_d;
         tie_q          <= tie_d;
         busy_q         <= busy_d;
         result_valid_q <= result_valid_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (start)                state_d = ACCUM;
         ACCUM:   if (step_en && last_step) state_d = SCAN;
         SCAN:    if (last_idx)             state_d = HOLD;
         HOLD:    if (handshake)            state_d = IDLE;
         default:                           state_d = IDLE;
      endcase
   end

   // Step counting, winner scan and result/handshake registers.
   // The result is captured on the last scan cycle; result_valid follows one
   // cycle into HOLD so it rises CLASS_COUNT+1 edges after the final step.
   always_comb begin
      step_cnt_d    = step_cnt_q;
      scan_idx_d    = '0;
      best_d        = best_q;
      best_idx_d    = best_idx_q;
      best_tie_d    = best_tie_q;
      class_idx_d   = class_idx_q;
      class_score_d = class_score_q;
      tie_d         = tie_q;

      if (clr_scores) begin
         step_cnt_d = '0;
      end else if (step_en) begin
         step_cnt_d = step_cnt_q + STEP_W'(1);
      end

      if (state_q == SCAN) begin
         scan_idx_d = last_idx ? '0 : scan_idx_q + IDX_WIDTH'(1);
         if (scan_idx_q == '0) begin
            best_d     = cand;
            best_idx_d = '0;
            best_tie_d = 1'b0;
         end else if (cand > best_q) begin
            best_d     = cand;
            best_idx_d = scan_idx_q;
            best_tie_d = 1'b0;
         end else if (cand == best_q) begin
            best_tie_d = 1'b1;
         end
         if (last_idx) begin
            class_idx_d   = best_idx_d;
            class_score_d = best_d;
            tie_d         = best_tie_d;
         end
      end

      busy_d         = (state_d != IDLE);
      result_valid_d = (state_q == HOLD) && !handshake;
   end

   assign busy         = busy_q;
   assign result_valid = result_valid_q;
   assign class_idx    = class_idx_q;
   assign class_score  = class_score_q;
   assign tie          = tie_q;

endmodule

// File: tb/tb_spike_vote_classifier.sv
// Scoreboard bench for spike_vote_classifier: a main instance (window 4,
// 8-bit scores) and a narrow instance (window 12, 4-bit scores) for clamping.
module tb_spike_vote_classifier;

   typedef struct {
      int idx;
      int score;
      int tie;
      int last_edge;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset;
   int         cyc = 0;
   int         n_tests = 0;
   int         n_fail = 0;

   // main instance signals
   logic       a_start, a_sv, a_ready, a_busy, a_rv, a_tie;
   logic [9:0] a_pos, a_neg;
   logic [3:0] a_idx;
   logic [7:0] a_score;

   // narrow-score instance signals
   logic       s_start, s_sv, s_ready, s_busy, s_rv, s_tie;
   logic [9:0] s_pos, s_neg;
   logic [3:0] s_idx;
   logic [3:0] s_score;

   exp_t       a_q[$];
   exp_t       s_q[$];
   bit         a_rv_seen = 1'b0;
   bit         s_rv_seen = 1'b0;
   exp_t       a_mon_e, s_mon_e;

   int         m_score[10];
   int         m_steps;

   spike_vote_classifier #(
      .CLASS_COUNT(10), .WINDOW_STEPS(4), .COUNT_WIDTH(8), .IDX_WIDTH(4)
   ) u_dut (
      .clk(clk), .reset(reset), .start(a_start), .step_valid(a_sv),
      .pos_spike_in(a_pos), .neg_spike_in(a_neg), .busy(a_busy),
      .result_valid(a_rv), .result_ready(a_ready), .class_idx(a_idx),
      .class_score(a_score), .tie(a_tie)
   );

   spike_vote_classifier #(
      .CLASS_COUNT(10), .WINDOW_STEPS(12), .COUNT_WIDTH(4), .IDX_WIDTH(4)
   ) u_sat (
      .clk(clk), .reset(reset), .start(s_start), .step_valid(s_sv),
      .pos_spike_in(s_pos), .neg_spike_in(s_neg), .busy(s_busy),
      .result_valid(s_rv), .result_ready(s_ready), .class_idx(s_idx),
      .class_score(s_score), .tie(s_tie)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input int act, input int exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------- reference model ----------------
   task automatic m_clear();
      for (int i = 0; i < 10; i++) m_score[i] = 0;
      m_steps = 0;
   endtask

   task automatic m_apply(input logic [9:0] p, input logic [9:0] n, input int w);
      int hi, lo, v;
      hi = (1 << (w - 1)) - 1;
      lo = -(1 << (w - 1));
      for (int i = 0; i < 10; i++) begin
         v = m_score[i] + int'(p[i]) - int'(n[i]);
         if (v > hi) v = hi;
         if (v < lo) v = lo;
         m_score[i] = v;
      end
      m_steps++;
   endtask

   function automatic exp_t m_result();
      exp_t r;
      r.idx = 0;
      r.score = m_score[0];
      r.tie = 0;
      r.last_edge = 0;
      for (int i = 1; i < 10; i++) begin
         if (m_score[i] > r.score) begin
            r.idx = i;
            r.score = m_score[i];
            r.tie = 0;
         end else if (m_score[i] == r.score) begin
            r.tie = 1;
         end
      end
      return r;
   endfunction

   // ---------------- monitors ----------------
   always @(negedge clk) begin
      if (a_rv && !a_rv_seen) begin
         if (a_q.size() == 0) begin
            check_eq("a_spurious_rv", int'(a_rv), 0);
         end else begin
            a_mon_e = a_q.pop_front();
            check_eq("a_class_idx", int'(a_idx), a_mon_e.idx);
            check_eq("a_class_score", int'($signed(a_score)), a_mon_e.score);
            check_eq("a_tie", int'(a_tie), a_mon_e.tie);
            check_eq("a_latency", cyc - a_mon_e.last_edge, 11);
         end
      end
      a_rv_seen = a_rv;
   end

   always @(negedge clk) begin
      if (s_rv && !s_rv_seen) begin
         if (s_q.size() == 0) begin
            check_eq("s_spurious_rv", int'(s_rv), 0);
         end else begin
            s_mon_e = s_q.pop_front();
            check_eq("s_class_idx", int'(s_idx), s_mon_e.idx);
            check_eq("s_class_score", int'($signed(s_score)), s_mon_e.score);
            check_eq("s_tie", int'(s_tie), s_mon_e.tie);
            check_eq("s_latency", cyc - s_mon_e.last_edge, 11);
         end
      end
      s_rv_seen = s_rv;
   end

   // ---------------- main-instance drivers ----------------
   task automatic a_begin();
      a_start = 1'b1;
      a_sv = 1'b1;          // must be ignored alongside start
      a_pos = '1;
      a_neg = '0;
      tick();
      a_start = 1'b0;
      a_sv = 1'b0;
      a_pos = '0;
      m_clear();
      check_eq("a_busy_after_start", int'(a_busy), 1);
   endtask

   task automatic a_step(input logic [9:0] p, input logic [9:0] n);
      exp_t r;
      a_sv = 1'b1;
      a_pos = p;
      a_neg = n;
      m_apply(p, n, 8);
      if (m_steps == 4) begin
         r = m_result();
         r.last_edge = cyc + 1;
         a_q.push_back(r);
      end
      tick();
      a_sv = 1'b0;
      a_pos = '0;
      a_neg = '0;
   endtask

   task automatic a_stall(input int n);
      for (int i = 0; i < n; i++) begin
         a_sv = 1'b0;
         a_pos = 10'($urandom);
         a_neg = 10'($urandom);
         tick();
      end
      a_pos = '0;
      a_neg = '0;
   endtask

   task automatic a_wait_rv(input int budget);
      int n;
      n = 0;
      while (!a_rv && n < budget) begin
         tick();
         n++;
      end
      if (!a_rv) check_eq("a_rv_timeout", int'(a_rv), 1);
   endtask

   task automatic a_accept();
      a_ready = 1'b1;
      tick();
      a_ready = 1'b0;
      check_eq("a_rv_drop", int'(a_rv), 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t e;
      reset = 1'b1;
      a_start = 0; a_sv = 0; a_ready = 0; a_pos = '0; a_neg = '0;
      s_start = 0; s_sv = 0; s_ready = 0; s_pos = '0; s_neg = '0;

      // 1: reset / idle behaviour
      for (int i = 0; i < 3; i++) begin
         a_sv = i[0];
         a_ready = ~i[0];
         a_pos = '1;
         tick();
         check_eq("rst_busy", int'(a_busy), 0);
         check_eq("rst_rv", int'(a_rv), 0);
         check_eq("rst_idx", int'(a_idx), 0);
         check_eq("rst_score", int'(a_score), 0);
         check_eq("rst_tie", int'(a_tie), 0);
      end
      reset = 1'b0;
      a_sv = 1'b1;
      a_ready = 1'b1;
      tick();
      a_sv = 1'b0;
      a_ready = 1'b0;
      a_pos = '0;
      check_eq("idle_busy", int'(a_busy), 0);
      check_eq("idle_rv", int'(a_rv), 0);

      // 2: basic win on class 3
      a_begin();
      for (int i = 0; i < 4; i++) a_step(10'b0000001000, '0);
      a_wait_rv(40);
      a_accept();

      // 3: stalls and mixed spikes
      a_begin();
      a_step(10'b0010100100, 10'b0010100000);
      a_stall(2);
      a_step(10'b0010100100, 10'b0000100000);
      a_stall(1);
      a_step(10'b0010100000, 10'b0000100000);
      a_stall(3);
      a_step(10'b0010100000, 10'b0000100000);
      a_wait_rv(40);
      a_accept();

      // 4: tie between classes 1 and 6
      a_begin();
      for (int i = 0; i < 3; i++) a_step(10'b0001000010, '0);
      a_step('0, '0);
      a_wait_rv(40);
      a_accept();

      // random windows
      for (int k = 0; k < 3; k++) begin
         a_begin();
         for (int j = 0; j < 4; j++) begin
            a_step(10'($urandom), 10'($urandom));
            a_stall(int'($urandom_range(0, 2)));
         end
         a_wait_rv(40);
         a_accept();
      end

      // 6a: backpressure, start ignored in HOLD and in the handshake cycle
      a_begin();
      for (int i = 0; i < 4; i++) a_step(10'b0000010000, 10'b0000000001);
      e = m_result();
      a_wait_rv(40);
      for (int i = 0; i < 5; i++) begin
         a_ready = 1'b0;
         a_start = 1'b1;
         tick();
         check_eq("hold_rv", int'(a_rv), 1);
         check_eq("hold_idx", int'(a_idx), e.idx);
         check_eq("hold_score", int'($signed(a_score)), e.score);
         check_eq("hold_tie", int'(a_tie), e.tie);
      end
      a_ready = 1'b1;
      a_start = 1'b1;
      tick();
      a_ready = 1'b0;
      a_start = 1'b0;
      check_eq("hs_rv_drop", int'(a_rv), 0);
      check_eq("hs_busy_drop", int'(a_busy), 0);
      tick();
      check_eq("hs_start_ignored", int'(a_busy), 0);
      check_eq("idle_keep_idx", int'(a_idx), e.idx);
      check_eq("idle_keep_score", int'($signed(a_score)), e.score);

      // 6b: abort mid-window with reset, then a clean window
      a_begin();
      a_step(10'b0100000000, '0);
      a_step(10'b0100000000, '0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check_eq("abort_busy", int'(a_busy), 0);
      check_eq("abort_rv", int'(a_rv), 0);
      a_stall(15);
      check_eq("abort_no_rv", int'(a_rv), 0);
      a_begin();
      for (int i = 0; i < 4; i++) a_step(10'b0000000100, '0);
      a_wait_rv(40);
      a_accept();

      // 5: saturation on the narrow instance
      s_start = 1'b1;
      tick();
      s_start = 1'b0;
      m_clear();
      for (int i = 0; i < 12; i++) begin
         s_sv = 1'b1;
         s_pos = 10'b1000000000;
         s_neg = 10'b0000000001;
         m_apply(s_pos, s_neg, 4);
         if (m_steps == 12) begin
            e = m_result();
            e.last_edge = cyc + 1;
            s_q.push_back(e);
         end
         tick();
         s_sv = 1'b0;
         s_pos = '0;
         s_neg = '0;
      end
      check_eq("sat_model_low", m_score[0], -8);
      begin
         int n;
         n = 0;
         while (!s_rv && n < 40) begin
            tick();
            n++;
         end
         if (!s_rv) check_eq("s_rv_timeout", int'(s_rv), 1);
      end
      s_ready = 1'b1;
      tick();
      s_ready = 1'b0;
      check_eq("s_rv_drop", int'(s_rv), 0);

      tick();
      tick();
      check_eq("a_sb_empty", a_q.size(), 0);
      check_eq("s_sb_empty", s_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/spike_vote_classifier.md
Name: spike_vote_classifier

Overview:
Output stage of the spiking digit classifier. It sits directly downstream of the final layer of spiking neurons and consumes their per-class positive/negative spike outputs over a fixed window of timesteps. It keeps a signed net spike score per class, then scans the scores sequentially to select the winning class. The result is presented on a valid/ready handshake to the display/UART logic.

Parameters:
CLASS_COUNT, 10, number of output neurons/classes (>=2)
WINDOW_STEPS, 64, timesteps accumulated per classification (>=1)
COUNT_WIDTH, 8, signed score width per class
IDX_WIDTH, 4, width of class index output; must satisfy 2**IDX_WIDTH >= CLASS_COUNT

Ports:
clk  input  1  single clock, all logic on posedge
reset  input  1  synchronous, active-high
start  input  1  begin new classification window; honoured only in IDLE
step_valid  input  1  current pos/neg vectors are one valid timestep
pos_spike_in  input  CLASS_COUNT  positive spike per class (bit i = class i)
neg_spike_in  input  CLASS_COUNT  negative spike per class
busy  output  1  high whenever state != IDLE
result_valid  output  1  result available; held until accepted
result_ready  input  1  consumer accepts result
class_idx  output  IDX_WIDTH  winning class index
class_score  output  COUNT_WIDTH  signed score of winner
tie  output  1  another class equals the winning score

Behaviour:
- Reset (synchronous, active-high): state=IDLE; busy=0, result_valid=0, class_idx=0, class_score=0, tie=0; all scores, step counter and scan index cleared. Reset mid-window or mid-scan aborts with no result produced.
- FSM states: IDLE, ACCUM, SCAN, HOLD.
- IDLE, start=1: clear all scores and the step counter, then go to ACCUM. step_valid in the same cycle as start is ignored.
- ACCUM: on each step_valid, for every class i, score[i] += pos[i] - neg[i]. pos and neg both set gives a net change of 0. Cycles with step_valid=0 are stalls and do not count.
  - Saturating arithmetic: clamp at +(2**(COUNT_WIDTH-1)-1) and -(2**(COUNT_WIDTH-1)). No wrap-around.
  - The step counter increments per accepted step. The step that makes the count equal WINDOW_STEPS is applied, then the next state is SCAN.
- SCAN: one class per cycle, index 0..CLASS_COUNT-1, taking CLASS_COUNT cycles.
  - Index 0 seeds best.
  - Later index replaces best only if strictly greater, so the lowest index wins ties.
  - tie is set if any later score equals the current best, and cleared when best is replaced.
  - After the last index, go to HOLD.
- HOLD: result_valid=1. class_idx, class_score and tie are stable and do not change while result_valid=1 && result_ready=0.
  - On result_valid && result_ready, next state is IDLE and result_valid drops next cycle.
  - class_idx, class_score and tie keep their last values until the next HOLD.
- Latency: result_valid rises on the clock edge exactly CLASS_COUNT+1 edges after the edge that samples the final step.
- Ignored inputs:
  - start is ignored outside IDLE, including the handshake cycle; a new window needs start in a later IDLE cycle.
  - step_valid is ignored in IDLE, SCAN and HOLD.
  - result_ready outside HOLD has no effect.
- busy is a registered decode: 1 in ACCUM, SCAN and HOLD.

Decomposition:
- Package snn_pkg holds the FSM state enum (IDLE, ACCUM, SCAN, HOLD) and the default constants CLASS_COUNT_DEF=10 and SCORE_WIDTH_DEF=8.
- One natural sub-module, spike_score_accum: a single-class signed saturating up/down counter with clear, enable, pos and neg inputs. It is instantiated CLASS_COUNT times via generate.
- The top level keeps the FSM, step counter, scan mux/comparator and result registers.

Test Plan:
1. Reset/idle: assert reset 3 cycles, toggle step_valid and result_ready -> busy=0, result_valid=0, class_idx=0, class_score=0, tie=0 throughout.
2. Basic win (CLASS_COUNT=10, WINDOW_STEPS=4): start, 4 steps with pos=10'b0000001000, neg=0 -> result_valid rises 11 edges after the 4th step; class_idx=3, class_score=4, tie=0.
3. Stalls and mixed spikes (WINDOW_STEPS=4): steps interleaved with step_valid=0 gaps; class 7 gets pos on all 4 steps plus neg on 1; class 2 gets pos on 2 steps; class 5 gets pos and neg together on all 4 -> class_idx=7, class_score=3, tie=0; class 5 nets 0.
4. Tie: class 1 and class 6 each get 3 pos spikes, no others -> class_idx=1, class_score=3, tie=1.
5. Saturation (COUNT_WIDTH=4, WINDOW_STEPS=12): class 0 neg every step, class 9 pos every step -> class 9 score=7 (clamped), class 0 score=-8; class_idx=9, class_score=7.
6. Handshake/abort:
   - Hold result_ready=0 for 5 cycles -> outputs stable and start ignored; ready=1 -> result_valid=0 next cycle.
   - Then start and reset after 2 steps -> IDLE, no result_valid; a new full window gives correct fresh scores.
